// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// FETCH_MISALIGN_TRAP_EN (optional) enables misaligned-redirect trapping.
package fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_STEP  = 4;
  // Widest PC a queue entry can carry; the top zero-extends narrower XLEN.
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_riscv_if.sv
// Redirect, instruction-memory and decode-side signals of the prefetch unit.
// Handshake: the queue head moves to decode on a cycle where instr_valid && instr_ready;
// instr_valid never depends on instr_ready. Memory answers every request exactly one cycle later.
interface fetch_prefetch_riscv_if #(
  parameter int XLEN = 64
);
  import fetch_pkg::*;

  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic                imem_req_valid;
  logic [XLEN-1:0]     imem_req_addr;
  logic                imem_rsp_valid;
  logic [INSTR_W-1:0]  imem_rsp_data;
  logic                instr_valid;
  logic                instr_ready;
  logic [INSTR_W-1:0]  instr_data;
  logic [XLEN-1:0]     instr_pc;
  logic                misalign_err;
  fetch_state_t        dbg_state;

  modport master (
    input  redirect_valid, redirect_pc, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
           misalign_err, dbg_state
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
           misalign_err, dbg_state
  );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two circular queue of fetched instructions with registered head and flush.
// Part of the prefetch unit (FETCH_MISALIGN_TRAP_EN does not affect this file).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Storage is not reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // The issue credit upstream must make a push into a full queue impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_prefetch_riscv.sv
// RISC-V instruction prefetcher: credit-limited fetch into a small queue, epoch-based redirect flush.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of silently aligning them.
module fetch_prefetch_riscv
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fetch_prefetch_riscv_if.master bus
);

  localparam int CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic [XLEN-1:0] redirect_tgt;
  logic            epoch_q;
  logic            inflight_q;
  logic            inflight_epoch_q;
  logic            redirect_misaligned;
  logic            issue_ok;
  logic            halted;
  logic            credit_ok;
  logic            issue;
  logic            push;
  logic            pop;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_tgt        = bus.redirect_pc;
  assign redirect_misaligned = (bus.redirect_pc[1:0] != 2'b00);
`else
  assign redirect_tgt        = bus.redirect_pc & ~XLEN'(3);
  assign redirect_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH_RUN;
    else        state_q <= state_d;
  end

  // Only a redirect can enter or leave the halted state.
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = redirect_misaligned ? FETCH_HALT : FETCH_RUN;
    end
  end

  always_comb begin
    issue_ok = 1'b0;
    halted   = 1'b0;
    case (state_q)
      FETCH_RUN:  issue_ok = 1'b1;
      FETCH_HALT: halted   = 1'b1;
      default:    issue_ok = 1'b0;
    endcase
  end

  // Credit counts the in-flight request so its response always finds a free slot.
  assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < DEPTH;
  assign issue     = rst_n && issue_ok && !bus.redirect_valid && credit_ok;
  assign pop       = (fifo_count != '0) && bus.instr_ready;
  assign push      = bus.imem_rsp_valid && inflight_q && (inflight_epoch_q == epoch_q)
                     && !bus.redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q       <= RESET_PC;
      inflight_pc_q    <= '0;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
    end else begin
      if (bus.redirect_valid) begin
        fetch_pc_q <= redirect_tgt;
        epoch_q    <= ~epoch_q;
      end else if (issue) begin
        fetch_pc_q <= fetch_pc_q + XLEN'(PC_STEP);
      end
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q    <= fetch_pc_q;
        inflight_epoch_q <= epoch_q;
      end
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = PC_MAX_W'(inflight_pc_q);
    push_entry.instr = bus.imem_rsp_data;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (fifo_count),
    .head      (head)
  );

  assign bus.imem_req_valid = issue;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = (fifo_count != '0);
  assign bus.instr_data     = head.instr;
  assign bus.instr_pc       = head.pc[XLEN-1:0];
  assign bus.dbg_state      = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.misalign_err   = halted;
`else
  assign bus.misalign_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_riscv.sv
// Scoreboard bench for fetch_prefetch_riscv with a one-cycle-latency instruction memory.
// Builds with or without FETCH_MISALIGN_TRAP_EN.
module tb_fetch_prefetch_riscv;
  import fetch_pkg::*;

  localparam int          XLEN     = 64;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fetch_prefetch_riscv_if #(.XLEN(XLEN)) bus ();

  fetch_prefetch_riscv #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          tests;
  int          fails;
  int          delivered;
  logic [63:0] exp_q[$];
  logic [63:0] model_pc;
  logic [63:0] exp_pc;
  bit          model_halt;

  function automatic logic [31:0] mem_word(logic [63:0] addr);
    return addr[31:0] ^ 32'hC0DE_0013;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) next_cycle();
  endtask

  // Leaves the bench 1 time unit into cycle 0 after reset release.
  task automatic do_reset(bit ready);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = ready;
    rst_n              = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic redirect(logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    next_cycle();
    bus.redirect_valid = 1'b0;
  endtask

  // Memory model: every request answered one cycle later with a PC-tagged word.
  always @(posedge clk) begin
    bus.imem_rsp_valid <= bus.imem_req_valid;
    bus.imem_rsp_data  <= mem_word(bus.imem_req_addr);
  end

  // Scoreboard: an issued request pushes its expected PC; delivery pops and compares.
  always @(negedge clk) begin
    int sz0;
    if (!rst_n) begin
      exp_q.delete();
      model_pc   = RESET_PC;
      model_halt = 1'b0;
    end else begin
      sz0 = exp_q.size();
      if (bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_empty_deliver", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_pc = exp_q.pop_front();
          check("instr_pc", bus.instr_pc, exp_pc);
          check("instr_data", 64'(bus.instr_data), 64'(mem_word(exp_pc)));
          delivered++;
        end
      end
      if (bus.redirect_valid) begin
        check("req_in_redirect", 64'(bus.imem_req_valid), 64'd0);
        exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        if (bus.redirect_pc[1:0] != 2'b00) begin
          model_halt = 1'b1;
        end else begin
          model_halt = 1'b0;
          model_pc   = bus.redirect_pc;
        end
`else
        model_pc = {bus.redirect_pc[63:2], 2'b00};
`endif
      end else if (bus.imem_req_valid) begin
        if (model_halt) begin
          check("req_while_halted", 64'(bus.imem_req_valid), 64'd0);
        end else begin
          check("req_addr", bus.imem_req_addr, model_pc);
          check("req_credit", 64'(sz0 < DEPTH), 64'd1);
          exp_q.push_back(model_pc);
          model_pc += 64'd4;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    delivered = 0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b1;

    // Reset values while held in reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_misalign", 64'(bus.misalign_err), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'(FETCH_RUN));
    next_cycle();
    rst_n = 1'b1;

    // Streaming from reset: first instruction in cycle 2, then one per cycle
    @(negedge clk);
    check("c0_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("c0_instr_valid", 64'(bus.instr_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("c1_instr_valid", 64'(bus.instr_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("c2_instr_valid", 64'(bus.instr_valid), 64'd1);
    check("c2_instr_pc", bus.instr_pc, RESET_PC);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      @(negedge clk);
      check("stream_valid", 64'(bus.instr_valid), 64'd1);
    end

    // Back-pressure fills exactly DEPTH entries, then drains in order
    do_reset(1'b0);
    run(8);
    @(negedge clk);
    check("full_req_low", 64'(bus.imem_req_valid), 64'd0);
    check("full_entries", 64'(exp_q.size()), 64'(DEPTH));
    check("full_head_pc", bus.instr_pc, RESET_PC);
    bus.instr_ready = 1'b1;
    run(10);

    // Redirect with 3 queued and 1 in flight
    do_reset(1'b0);
    run(4);
    redirect(64'h100);
    @(negedge clk);
    check("flush_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("post_redirect_req", bus.imem_req_addr, 64'h100);
    bus.instr_ready = 1'b1;
    run(8);

    // Back-to-back redirects: only the last target is fetched
    redirect(64'h40);
    redirect(64'h80);
    @(negedge clk);
    check("b2b_addr", bus.imem_req_addr, 64'h80);
    run(8);

    // Misaligned redirect
    redirect(64'h102);
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_err_set", 64'(bus.misalign_err), 64'd1);
    check("mis_state", 64'(bus.dbg_state), 64'(FETCH_HALT));
    run(4);
    @(negedge clk);
    check("mis_no_req", 64'(bus.imem_req_valid), 64'd0);
    redirect(64'h200);
    @(negedge clk);
    check("mis_err_clr", 64'(bus.misalign_err), 64'd0);
    check("mis_resume_addr", bus.imem_req_addr, 64'h200);
`else
    check("mis_err_tied", 64'(bus.misalign_err), 64'd0);
    check("mis_aligned_addr", bus.imem_req_addr, 64'h100);
`endif
    run(8);

    // Asynchronous reset with a full queue
    bus.instr_ready = 1'b0;
    run(8);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.instr_valid), 64'd0);
    check("async_rst_req", 64'(bus.imem_req_valid), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("refetch_addr", bus.imem_req_addr, RESET_PC);
    run(10);

    // Random back-pressure and aligned redirects
    for (int i = 0; i < 300; i++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'($urandom_range(0, 1023)) << 2;
      end else begin
        bus.redirect_valid = 1'b0;
      end
      next_cycle();
    end
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    run(10);
    check("progress", 64'(delivered > 150), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_riscv.md
FETCH_PREFETCH_RISCV -- requirements
Module: fetch_prefetch_riscv

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC/address width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump taken, replaces branch_en.
REQ-007 SHALL have port redirect_pc  input  XLEN  signed redirect target.
REQ-008 SHALL have port imem_req_valid  output  1  fetch request.
REQ-009 SHALL have port imem_req_addr  output  XLEN  byte address of the 32-bit word.
REQ-010 SHALL have port imem_rsp_valid  input  1  response, exactly 1 cycle after each request, in order.
REQ-011 SHALL have port imem_rsp_data  input  32  instruction, little-endian assembled.
REQ-012 SHALL have port instr_valid  output  1  queue head valid.
REQ-013 SHALL have port instr_ready  input  1  decode accepts head.
REQ-014 SHALL have ports instr_data  output  32 and instr_pc  output  XLEN  head instruction and its PC.
REQ-015 SHALL have port misalign_err  output  1  sticky misaligned-redirect flag (macro only).

Function
REQ-016 SHALL issue imem_req_valid=1 with imem_req_addr=fetch_pc when (count + inflight) < DEPTH and no redirect this cycle; fetch_pc += 4 on issue.
REQ-017 SHALL set inflight=1 the cycle after an issue, and 0 otherwise; every cycle at most one request.
REQ-018 SHALL push {pc, imem_rsp_data} into the queue on imem_rsp_valid when the response epoch matches the current epoch.
REQ-019 SHALL present the head registered: instr_valid = (count != 0); no bypass, so the first instruction appears 2 cycles after its request.
REQ-020 SHALL pop the head when instr_valid && instr_ready; simultaneous push and pop keeps count unchanged.
REQ-021 SHALL never overflow: the credit rule in REQ-016 guarantees a push never targets a full queue; a push when full is an assertion failure.
REQ-022 SHALL, on redirect_valid, complete any same-cycle pop, then flush the queue (count=0 next cycle), toggle the 1-bit epoch, and load fetch_pc=redirect_pc.
REQ-023 SHALL drop the response of a request issued before a redirect (epoch mismatch), including one arriving in the redirect cycle.
REQ-024 SHALL issue no request in a redirect cycle; the first request to the target issues the following cycle.
REQ-025 SHALL handle back-to-back redirects: only the last target is fetched.
REQ-026 SHALL wrap the read/write pointers modulo DEPTH; count ranges 0..DEPTH.

Reset
REQ-027 SHALL, on rst_n=0 (asynchronous), set fetch_pc=RESET_PC, count=0, pointers=0, epoch=0, inflight=0, imem_req_valid=0, instr_valid=0, misalign_err=0; queue contents are don't-care.
REQ-028 SHALL, on reset mid-operation, discard all queued and in-flight instructions; a response arriving in the first cycle after deassertion is ignored.

Configuration
REQ-029 SHALL compile misalignment checking only with FETCH_MISALIGN_TRAP_EN defined.
REQ-030 SHALL, with the macro, on a redirect with redirect_pc[1:0]!=0: set misalign_err=1, flush, and stop issuing until the next aligned redirect, which clears misalign_err.
REQ-031 SHALL, without the macro, force redirect_pc[1:0] to 00 and tie misalign_err to 0.

Structure
REQ-032 SHALL place fetch_entry_t {pc, instr}, INSTR_W=32, and PC_STEP=4 in shared package fetch_pkg.
REQ-033 SHALL implement the queue as sub-module fetch_fifo (push, pop, flush, count, head) parametrised by DEPTH and the entry type.

Verification
REQ-034 Reset release, RESET_PC=0, instr_ready=1, memory returns PC-tagged words -> requests at 0,4,8,...; instr_valid first high in cycle 2 with instr_pc=0, then one instruction per cycle.
REQ-035 instr_ready=0, DEPTH=4 -> exactly 4 entries fill (PCs 0..C), imem_req_valid low afterwards; instr_ready=1 -> drains in order, fetching resumes at 0x10.
REQ-036 Redirect to 0x100 while queue holds 3 entries and one request is in flight -> next cycle count=0, in-flight response dropped, next request at 0x100, next instr_pc=0x100.
REQ-037 Redirect to 0x40 then 0x80 in consecutive cycles -> no instruction from 0x40 delivered; first instr_pc=0x80.
REQ-038 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_err=1, no requests; redirect to 0x200 -> misalign_err=0, fetch at 0x200; without the macro, 0x102 fetches 0x100.
REQ-039 rst_n pulsed low mid-stream with a full queue -> instr_valid=0 immediately; refetch starts at RESET_PC.
